floatmul_operand_queue: RTL and testbench
=========================================

Name: floatmul_operand_queue

Overview:
Upstream operand stage for floatmul. It buffers the A and B operand streams in two independent FIFOs, so producers can deliver operands at different times. Its outputs drive floatmul's a_*/b_* handshakes directly. floatmul pops A and B in the same cycle; each queue still obeys its own valid/ready.

Parameters:
DEPTH, 4, entries per operand FIFO; legal 2..16, need not be a power of two.
CNT_W, $clog2(DEPTH+1), width of occupancy counts (derived; not overridden).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
busy  out  1  any entry held in either FIFO
in_a_valid  in  1  A producer valid
in_a_payload  in  float32_t  A operand
in_a_ready  out  1  A FIFO can accept
in_b_valid  in  1  B producer valid
in_b_payload  in  float32_t  B operand
in_b_ready  out  1  B FIFO can accept
a_valid  out  1  head of A FIFO valid, to floatmul a_valid
a_payload  out  float32_t  head of A FIFO
a_ready  in  1  from floatmul a_ready
b_valid  out  1  head of B FIFO valid
b_payload  out  float32_t  head of B FIFO
b_ready  in  1  from floatmul b_ready
a_count  out  CNT_W  A occupancy
b_count  out  CNT_W  B occupancy

Behaviour:
- Reset (rst=0, async): counts 0, read/write pointers 0. a_valid, b_valid and busy are 0. in_a_ready and in_b_ready are 1 one cycle after release (0 while rst=0). Payload storage is not reset; a_payload/b_payload are don't-care while the matching valid is 0.
- Channels are identical and fully independent. There is no cross-coupling, and there is no combinational path from in_* to out_*.
- Push: in_x_valid & in_x_ready at the edge writes the payload at wptr, advances wptr, and increments the count.
- Pop: x_valid & x_ready at the edge advances rptr and decrements the count.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Latency: an entry pushed into an empty FIFO appears on x_valid the next cycle. There is no same-cycle bypass.
- in_x_ready = (count != DEPTH). It is registered-state only and does not depend on x_ready. At full, a simultaneous pop does not admit a push that cycle.
- x_valid = (count != 0). x_payload = mem[rptr], valid combinationally from registered state.
- Pointer wrap: a pointer equal to DEPTH-1 wraps to 0 (explicit compare, not modulo 2^n).
- Ordering: strict FIFO per channel.
- Stability: while x_valid=1 and x_ready=0, x_payload holds stable.
- Counts never exceed DEPTH and never underflow.
- busy = (a_count != 0) | (b_count != 0).
- Reset mid-operation: all queued operands are discarded immediately. Outputs go to reset values asynchronously.
- Payload passes through bit-exact unless the optional feature is enabled.

Optional Feature:
FLOATMUL_OPQ_FTZ_EN
- Defined: on push, an operand with exponent==0 is stored with its mantissa forced to 0. Sign is kept, so subnormals become signed zero before reaching floatmul. All other operands are stored unchanged.
- Undefined: payload stored unmodified, and no extra logic is generated.

Decomposition:
- float32_t stays in floatmul_pkg.
- Add to floatmul_pkg: localparam FLOATMUL_OPQ_DEPTH_MAX=16 and function is_subnormal(float32_t).
- One sub-module, floatmul_opq_fifo, is instantiated twice. It is a single-channel float32_t FIFO with DEPTH, push/pop handshake and count. The FTZ conditioning is applied in the top before the FIFO write.

Test Plan:
- Reset then idle: after rst release, in_a_ready=in_b_ready=1, a_valid=b_valid=0, busy=0, counts 0.
- Ordering/latency: push A=0x3F800000 at cycle 0 → a_valid=1 and a_payload=0x3F800000 at cycle 1, busy=1. Push B=0x40000000 at cycle 3 → both valid at cycle 4. Hold a_ready=b_ready=1 → both pop at cycle 4, busy=0 at cycle 5.
- Full boundary, DEPTH=3: push A 1,2,3 with a_ready=0 → a_count=3, in_a_ready=0. A 4th in_a_valid is not accepted even if a_ready=1 that cycle. Next cycle in_a_ready=1. Drain yields 1,2,3 in order.
- Wrap, DEPTH=3: 10 back-to-back push+pop pairs with values 0..9 → output sequence 0..9 exactly, a_count constant at 1.
- Async reset mid-stream: with a_count=2, drop rst between edges → a_valid=0 and a_count=0 immediately. After release, no stale data is emitted.
- FTZ: with FLOATMUL_OPQ_FTZ_EN, push {sign=1, exp=0, mant=0x000123} → output {1, 0x00, 0x000000}. Without the macro → output equals the input.

Source files
------------

// File: rtl/floatmul_pkg.sv
// floatmul_pkg: shared float32 type and operand-queue helpers for floatmul
package floatmul_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } float32_t;

   localparam int FLOATMUL_OPQ_DEPTH_MAX = 16;

   function automatic logic is_subnormal(float32_t f);
      return (f.exp == 8'd0) && (f.mant != 23'd0);
   endfunction

endpackage

// File: rtl/floatmul_opq_fifo.sv
// floatmul_opq_fifo: single-channel float32 FIFO with valid/ready push and pop and occupancy count
module floatmul_opq_fifo
   import floatmul_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid,
   input  float32_t         push_data,
   output logic             push_ready,
   output logic             pop_valid,
   output float32_t         pop_data,
   input  logic             pop_ready,
   output logic [CNT_W-1:0] count
);

   float32_t         mem [DEPTH];
   logic [PTR_W-1:0] wptr, rptr;
   logic             en;
   logic             push, pop;

   // en keeps push_ready low during reset and for the first edge after release
   assign push_ready = en && (count != CNT_W'(DEPTH));
   assign pop_valid  = count != '0;
   assign pop_data   = mem[rptr];
   assign push       = push_valid && push_ready;
   assign pop        = pop_valid && pop_ready;

   // pointers wrap by explicit compare so DEPTH need not be a power of two
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en    <= 1'b0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         en    <= 1'b1;
         if (push) wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
         if (pop) rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // payload storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= push_data;
   end

endmodule

// File: rtl/floatmul_operand_queue.sv
// floatmul_operand_queue: independent A/B operand FIFOs feeding floatmul; optional FLOATMUL_OPQ_FTZ_EN flushes subnormals to signed zero
module floatmul_operand_queue
   import floatmul_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   output logic             busy,
   input  logic             in_a_valid,
   input  float32_t         in_a_payload,
   output logic             in_a_ready,
   input  logic             in_b_valid,
   input  float32_t         in_b_payload,
   output logic             in_b_ready,
   output logic             a_valid,
   output float32_t         a_payload,
   input  logic             a_ready,
   output logic             b_valid,
   output float32_t         b_payload,
   input  logic             b_ready,
   output logic [CNT_W-1:0] a_count,
   output logic [CNT_W-1:0] b_count
);

   float32_t a_wr, b_wr;

`ifdef FLOATMUL_OPQ_FTZ_EN
   assign a_wr = is_subnormal(in_a_payload) ? '{sign: in_a_payload.sign, exp: 8'd0, mant: 23'd0} : in_a_payload;
   assign b_wr = is_subnormal(in_b_payload) ? '{sign: in_b_payload.sign, exp: 8'd0, mant: 23'd0} : in_b_payload;
`else
   assign a_wr = in_a_payload;
   assign b_wr = in_b_payload;
`endif

   assign busy = (a_count != '0) | (b_count != '0);

   floatmul_opq_fifo #(.DEPTH(DEPTH)) u_fifo_a (
      .clk        (clk),
      .rst        (rst),
      .push_valid (in_a_valid),
      .push_data  (a_wr),
      .push_ready (in_a_ready),
      .pop_valid  (a_valid),
      .pop_data   (a_payload),
      .pop_ready  (a_ready),
      .count      (a_count)
   );

   floatmul_opq_fifo #(.DEPTH(DEPTH)) u_fifo_b (
      .clk        (clk),
      .rst        (rst),
      .push_valid (in_b_valid),
      .push_data  (b_wr),
      .push_ready (in_b_ready),
      .pop_valid  (b_valid),
      .pop_data   (b_payload),
      .pop_ready  (b_ready),
      .count      (b_count)
   );

endmodule

// File: tb/tb_floatmul_operand_queue.sv
// tb_floatmul_operand_queue: directed and random checks of the operand queue against a queue-based model
module tb_floatmul_operand_queue;
   import floatmul_pkg::*;

   localparam int D = 3;
   localparam int CW = $clog2(D + 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy;
   logic in_a_valid = 1'b0, in_b_valid = 1'b0;
   float32_t in_a_payload = '0, in_b_payload = '0;
   logic in_a_ready, in_b_ready;
   logic a_valid, b_valid;
   float32_t a_payload, b_payload;
   logic a_ready = 1'b0, b_ready = 1'b0;
   logic [CW-1:0] a_count, b_count;

   int passed = 0;
   int total = 0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   bit rdy_m = 1'b0;

   always #5 clk = ~clk;

   floatmul_operand_queue #(.DEPTH(D)) dut (
      .clk(clk), .rst(rst), .busy(busy),
      .in_a_valid(in_a_valid), .in_a_payload(in_a_payload), .in_a_ready(in_a_ready),
      .in_b_valid(in_b_valid), .in_b_payload(in_b_payload), .in_b_ready(in_b_ready),
      .a_valid(a_valid), .a_payload(a_payload), .a_ready(a_ready),
      .b_valid(b_valid), .b_payload(b_payload), .b_ready(b_ready),
      .a_count(a_count), .b_count(b_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [31:0] cond(input logic [31:0] x);
`ifdef FLOATMUL_OPQ_FTZ_EN
      if (((x >> 23) & 32'hff) == 32'd0) return x & 32'h8000_0000;
`endif
      return x;
   endfunction

   task automatic observe();
      chk("in_a_ready", 32'(in_a_ready), 32'(rdy_m && qa.size() < D));
      chk("in_b_ready", 32'(in_b_ready), 32'(rdy_m && qb.size() < D));
      chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
      chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
      chk("a_count", 32'(a_count), qa.size());
      chk("b_count", 32'(b_count), qb.size());
      chk("busy", 32'(busy), 32'(qa.size() != 0 || qb.size() != 0));
      if (qa.size() != 0) chk("a_payload", a_payload, qa[0]);
      if (qb.size() != 0) chk("b_payload", b_payload, qb[0]);
   endtask

   task automatic cycle();
      bit pa, pb, oa, ob;
      @(negedge clk);
      observe();
      pa = in_a_valid && rdy_m && qa.size() < D;
      pb = in_b_valid && rdy_m && qb.size() < D;
      oa = a_ready && qa.size() > 0;
      ob = b_ready && qb.size() > 0;
      @(posedge clk);
      if (oa) void'(qa.pop_front());
      if (ob) void'(qb.pop_front());
      if (pa) qa.push_back(cond(in_a_payload));
      if (pb) qb.push_back(cond(in_b_payload));
      rdy_m = 1'b1;
      #1;
   endtask

   initial begin
      logic [31:0] ftz_exp;
      // reset held, then released between edges
      #12;
      observe();
      chk("rst_a_ready", 32'(in_a_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("rel_a_ready", 32'(in_a_ready), 32'd0);
      @(posedge clk);
      rdy_m = 1'b1;
      #1;
      cycle();
      chk("idle_a_ready", 32'(in_a_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      // latency and ordering
      in_a_valid = 1'b1; in_a_payload = 32'h3F80_0000;
      cycle();
      in_a_valid = 1'b0;
      chk("lat_a_valid", 32'(a_valid), 32'd1);
      chk("lat_a_payload", a_payload, 32'h3F80_0000);
      chk("lat_busy", 32'(busy), 32'd1);
      cycle();
      cycle();
      in_b_valid = 1'b1; in_b_payload = 32'h4000_0000;
      cycle();
      in_b_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
      chk("both_valid", 32'({a_valid, b_valid}), 32'd3);
      cycle();
      a_ready = 1'b0; b_ready = 1'b0;
      chk("drained_busy", 32'(busy), 32'd0);
      cycle();
      // full boundary
      for (int v = 1; v <= 3; v++) begin
         in_a_valid = 1'b1; in_a_payload = v;
         cycle();
      end
      chk("full_count", 32'(a_count), 32'd3);
      chk("full_ready", 32'(in_a_ready), 32'd0);
      in_a_payload = 32'd4; a_ready = 1'b1;
      cycle();
      in_a_valid = 1'b0;
      chk("after_full_ready", 32'(in_a_ready), 32'd1);
      chk("after_full_head", a_payload, 32'd2);
      cycle();
      cycle();
      cycle();
      // pointer wrap with steady occupancy of one
      a_ready = 1'b0; in_a_valid = 1'b1; in_a_payload = 32'd0;
      cycle();
      for (int i = 1; i <= 9; i++) begin
         in_a_payload = i; a_ready = 1'b1;
         cycle();
         chk("wrap_count", 32'(a_count), 32'd1);
      end
      in_a_valid = 1'b0;
      chk("wrap_last", a_payload, 32'd9);
      cycle();
      a_ready = 1'b0;
      cycle();
      // asynchronous reset mid-stream
      in_a_valid = 1'b1; in_a_payload = 32'hAAAA_AAAA;
      cycle();
      in_a_payload = 32'h5555_5555;
      cycle();
      in_a_valid = 1'b0;
      chk("pre_rst_count", 32'(a_count), 32'd2);
      #2 rst = 1'b0;
      #1;
      chk("arst_a_valid", 32'(a_valid), 32'd0);
      chk("arst_a_count", 32'(a_count), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      qa.delete(); qb.delete(); rdy_m = 1'b0;
      observe();
      #3 rst = 1'b1;
      @(posedge clk);
      rdy_m = 1'b1;
      #1;
      a_ready = 1'b1;
      cycle();
      cycle();
      chk("post_rst_valid", 32'(a_valid), 32'd0);
      // subnormal conditioning
      a_ready = 1'b0; in_a_valid = 1'b1; in_a_payload = 32'h8000_0123;
      cycle();
      in_a_valid = 1'b0;
`ifdef FLOATMUL_OPQ_FTZ_EN
      ftz_exp = 32'h8000_0000;
`else
      ftz_exp = 32'h8000_0123;
`endif
      chk("ftz_payload", a_payload, ftz_exp);
      a_ready = 1'b1;
      cycle();
      // random traffic on both channels
      for (int n = 0; n < 400; n++) begin
         in_a_valid = 1'($urandom_range(0, 1));
         in_b_valid = 1'($urandom_range(0, 1));
         in_a_payload = $urandom;
         in_b_payload = $urandom;
         if ($urandom_range(0, 3) == 0) in_a_payload = in_a_payload & 32'h807F_FFFF;
         if ($urandom_range(0, 3) == 0) in_b_payload = in_b_payload & 32'h807F_FFFF;
         a_ready = 1'($urandom_range(0, 1));
         b_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      in_a_valid = 1'b0; in_b_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
      for (int n = 0; n < 4; n++) cycle();
      chk("final_busy", 32'(busy), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
